// File: rtl/mmu_tile_ctrl.sv
// mmu_tile_ctrl: sequences the mmu datapath over a grid of output tiles.
// Tiles are walked row-major and the K reduction runs innermost.
// Each step loads the operands, runs the mmu once and, after the last K step,
// hands the finished tile to writeback.
//
// Ports
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   start_i, m/n/k_tiles_i               job request and tile counts (latched on accept)
//   busy_o, done_o, err_o                job status (err_o is sticky, cleared on start)
//   tile_row_o, tile_col_o, tile_k_o     current tile indices for operand fetch
//   ld_req_o / ld_ack_i                  operand load handshake
//   accum_clr_o                          first K step, so accumulate input is zero
//   mmu_enable_o / mmu_data_ready_i      mmu level enable and completion pulse
//   wr_valid_o / wr_ready_i              writeback handshake for the finished tile
//
// Optional feature: define MMU_CTRL_TIMEOUT_EN to add a COMPUTE watchdog.
// The watchdog aborts the job with err_o=1 after TIMEOUT_CYC cycles in COMPUTE.
// Without it, err_o stays 0 and COMPUTE waits indefinitely.
module mmu_tile_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] m_tiles_i,
  input  logic [CNT_W-1:0] n_tiles_i,
  input  logic [CNT_W-1:0] k_tiles_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] tile_row_o,
  output logic [CNT_W-1:0] tile_col_o,
  output logic [CNT_W-1:0] tile_k_o,
  output logic             ld_req_o,
  input  logic             ld_ack_i,
  output logic             accum_clr_o,
  output logic             mmu_enable_o,
  input  logic             mmu_data_ready_i,
  output logic             wr_valid_o,
  input  logic             wr_ready_i
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_WRITE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d, kk_q, kk_d;
  logic             err_q, err_d;
  logic             tmo;

`ifdef MMU_CTRL_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
  logic [TC_W-1:0] tcnt_q;

  // Counts cycles spent in COMPUTE; any other state restarts it, so it is
  // zero on every COMPUTE entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 tcnt_q <= '0;
    else if (state_q != S_COMPUTE) tcnt_q <= '0;
    else                         tcnt_q <= tcnt_q + 1'b1;
  end

  assign tmo = (state_q == S_COMPUTE) && !mmu_data_ready_i &&
               (tcnt_q == TC_W'(TIMEOUT_CYC - 1));
`else
  wire unused_timeout = |TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kk_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kk_q    <= kk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    kk_d    = kk_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        err_d = 1'b0;
        if (|m_tiles_i && |n_tiles_i && |k_tiles_i) begin
          m_d     = m_tiles_i;
          n_d     = n_tiles_i;
          k_d     = k_tiles_i;
          row_d   = '0;
          col_d   = '0;
          kk_d    = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_LOAD: if (ld_ack_i) state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (mmu_data_ready_i) begin
          if (kk_q == k_q - 1'b1) begin
            state_d = S_WRITE;
          end else begin
            // Next step accumulates onto the mat_out produced by this one.
            kk_d    = kk_q + 1'b1;
            state_d = S_LOAD;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WRITE: if (wr_ready_i) begin
        kk_d = '0;
        if (col_q == n_q - 1'b1) begin
          col_d = '0;
          if (row_q == m_q - 1'b1) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign ld_req_o     = (state_q == S_LOAD);
  assign mmu_enable_o = (state_q == S_COMPUTE);
  assign wr_valid_o   = (state_q == S_WRITE);
  assign accum_clr_o  = (ld_req_o || mmu_enable_o) && (kk_q == '0);
  assign tile_row_o   = row_q;
  assign tile_col_o   = col_q;
  assign tile_k_o     = kk_q;

endmodule

// File: tb/tb_mmu_tile_ctrl.sv
module tb_mmu_tile_ctrl;
  localparam int CW = 8;

  logic          clk, rst_n, start;
  logic [CW-1:0] m_tiles, n_tiles, k_tiles;
  logic          busy, done, err;
  logic [CW-1:0] tile_row, tile_col, tile_k;
  logic          ld_req, ld_ack, accum_clr, mmu_enable, mmu_data_ready;
  logic          wr_valid, wr_ready;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [CW-1:0] r; logic [CW-1:0] c; } tile_t;
  tile_t sb_q[$];

  mmu_tile_ctrl #(.CNT_W(CW), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .m_tiles_i(m_tiles), .n_tiles_i(n_tiles), .k_tiles_i(k_tiles),
    .busy_o(busy), .done_o(done), .err_o(err),
    .tile_row_o(tile_row), .tile_col_o(tile_col), .tile_k_o(tile_k),
    .ld_req_o(ld_req), .ld_ack_i(ld_ack), .accum_clr_o(accum_clr),
    .mmu_enable_o(mmu_enable), .mmu_data_ready_i(mmu_data_ready),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mmu: data_ready pulses in the second cycle of enable.
  logic [7:0] en_cnt;
  logic       mmu_dead;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) en_cnt <= '0;
    else        en_cnt <= mmu_enable ? en_cnt + 8'd1 : 8'd0;
  assign mmu_data_ready = mmu_enable && (en_cnt == 8'd1) && !mmu_dead;

  // Runs one job; expected results come from a scoreboard of tiles pushed at
  // start and a local (row,col,k) model advanced by observed handshakes.
  task automatic run_job(input int m, input int n, input int k,
                         input int ld_dly, input int wr_dly,
                         input int exp_done, input bit do_abort);
    int ld_left, wr_left, er, ec, ek, nld, nen, nwr, cyc;
    bit got_done, prev_en;
    tile_t f;
    ld_left = ld_dly; wr_left = wr_dly;
    er = 0; ec = 0; ek = 0; nld = 0; nen = 0; nwr = 0; cyc = 0;
    got_done = 0; prev_en = 0;
    if (m != 0 && n != 0 && k != 0)
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) sb_q.push_back({CW'(r), CW'(c)});
    @(negedge clk);
    start = 1; m_tiles = CW'(m); n_tiles = CW'(n); k_tiles = CW'(k);
    @(posedge clk); #1;
    start = 0;
    // Count inputs changing while busy must not matter.
    m_tiles = CW'($urandom); n_tiles = CW'($urandom); k_tiles = CW'($urandom);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start act=%b req=0", err); end
    while (cyc < 3000) begin
      @(negedge clk); cyc++;
      if (do_abort && mmu_enable && tile_row == 1 && tile_col == 0 && tile_k == 2) return;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy cyc=%0d act=%b req=1", cyc, busy); end
      total++;
      if (accum_clr !== ((ld_req || mmu_enable) && ek == 0)) begin
        bad++; $display("FAIL accum_clr cyc=%0d act=%b k_model=%0d", cyc, accum_clr, ek);
      end
      if (mmu_enable && !prev_en) nen++;
      prev_en = mmu_enable;
      ld_ack = 0; wr_ready = 0;
      if (ld_req) begin
        total++;
        if ({tile_row, tile_col, tile_k} !== {CW'(er), CW'(ec), CW'(ek)}) begin
          bad++;
          $display("FAIL ld_idx cyc=%0d act=(%0d,%0d,%0d) req=(%0d,%0d,%0d)",
                   cyc, tile_row, tile_col, tile_k, er, ec, ek);
        end
        if (ld_left > 0) ld_left--;
        else begin ld_ack = 1; nld++; end
      end
      if (mmu_enable && mmu_data_ready && ek != k - 1) ek++;
      if (wr_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL wr_unexpected cyc=%0d act=(%0d,%0d)", cyc, tile_row, tile_col);
        end else begin
          f = sb_q[0];
          if ({tile_row, tile_col} !== {f.r, f.c}) begin
            bad++;
            $display("FAIL wr_idx cyc=%0d act=(%0d,%0d) req=(%0d,%0d)",
                     cyc, tile_row, tile_col, f.r, f.c);
          end
        end
        if (wr_left > 0) wr_left--;
        else begin
          wr_ready = 1; nwr++;
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          ek = 0; ec++;
          if (ec == n) begin ec = 0; er++; end
        end
      end
      if (done) begin got_done = 1; break; end
    end
    ld_ack = 0; wr_ready = 0;
    total++;
    if (!got_done || cyc != exp_done) begin
      bad++; $display("FAIL done_cycle act=%0d got=%b req=%0d", cyc, got_done, exp_done);
    end
    total++;
    if (sb_q.size() != 0 || nwr != m * n * (k != 0 ? 1 : 0) * (m != 0 && n != 0 ? 1 : 0)) begin
      bad++; $display("FAIL writes act=%0d left=%0d", nwr, sb_q.size());
    end
    total++;
    if (nld != ((m != 0 && n != 0) ? m * n * k : 0) ||
        nen != ((m != 0 && n != 0) ? m * n * k : 0)) begin
      bad++; $display("FAIL ld_en_count ld=%0d en=%0d req=%0d", nld, nen, m * n * k);
    end
    sb_q.delete();
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL done_one_cycle act done=%b busy=%b req=0,0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; ld_ack = 0; wr_ready = 0; mmu_dead = 0;
    m_tiles = '0; n_tiles = '0; k_tiles = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err, ld_req, accum_clr, mmu_enable, wr_valid, tile_row, tile_col, tile_k} !== '0) begin
      bad++; $display("FAIL reset_state busy=%b done=%b ld=%b en=%b wr=%b", busy, done, ld_req, mmu_enable, wr_valid);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();     run_job(1, 1, 1, 0, 0, 5, 0);  endtask
  task automatic test_grid();       run_job(2, 3, 4, 0, 0, 79, 0); endtask
  task automatic test_backpressure(); run_job(2, 3, 4, 3, 5, 87, 0); endtask
  task automatic test_zero_count();
    run_job(3, 2, 0, 0, 0, 1, 0);
    run_job(0, 5, 5, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    run_job(2, 3, 4, 0, 0, 0, 1);
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy, done, err, ld_req, accum_clr, mmu_enable, wr_valid, tile_row, tile_col, tile_k} !== '0) begin
      bad++; $display("FAIL async_reset busy=%b en=%b idx=(%0d,%0d,%0d)", busy, mmu_enable, tile_row, tile_col, tile_k);
    end
    sb_q.delete();
    ld_ack = 0; wr_ready = 0;
    @(negedge clk); rst_n = 1;
    run_job(1, 2, 2, 0, 0, 15, 0);
  endtask

`ifdef MMU_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, en_cyc, nwr;
    bit got_done;
    cyc = 0; en_cyc = 0; nwr = 0; got_done = 0;
    mmu_dead = 1;
    @(negedge clk);
    start = 1; m_tiles = 8'd1; n_tiles = 8'd1; k_tiles = 8'd1;
    @(posedge clk); #1 start = 0;
    while (cyc < 200) begin
      @(negedge clk); cyc++;
      ld_ack = ld_req; wr_ready = 1;
      if (mmu_enable) en_cyc++;
      if (wr_valid) nwr++;
      if (done) begin got_done = 1; break; end
    end
    total++;
    if (!got_done || en_cyc != 8 || nwr != 0) begin
      bad++; $display("FAIL timeout act en_cyc=%0d wr=%0d done=%b req=8,0,1", en_cyc, nwr, got_done);
    end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL timeout_err act=%b req=1", err); end
    ld_ack = 0; wr_ready = 0; mmu_dead = 0;
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky act=%b req=1", err); end
    run_job(1, 1, 1, 0, 0, 5, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_grid();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
`ifdef MMU_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_tile_ctrl.md
# mmu_tile_ctrl

Tile scheduler that sequences the `mmu` datapath to compute a large matrix product C = A·B as a grid of output tiles. It walks tiles in row-major order and runs the K reduction innermost, accumulating through the `mmu` accumulate input. For each step it handshakes operand loads with the tile buffers, drives the `mmu` enable level, waits for its `data_ready` pulse, and hands each finished output tile to writeback.

## Interface
- `CNT_W`, 8: width of tile counts and tile indices.
- `TIMEOUT_CYC`, 64: watchdog limit in cycles (used only with `MMU_CTRL_TIMEOUT_EN`).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a job; sampled only in IDLE.
- `m_tiles`, `n_tiles`, `k_tiles`  in  CNT_W each  tile counts (rows, cols, reduction); latched when start is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse at job end.
- `err`  out  1  sticky watchdog flag; cleared when the next start is accepted.
- `tile_row`, `tile_col`, `tile_k`  out  CNT_W each  current tile indices used for operand fetch.
- `ld_req`  out  1  operand load request.
- `ld_ack`  in  1  operands for the current indices are present on the `mmu` inputs.
- `accum_clr`  out  1  high when tile_k==0; upstream forces `mat_in_accum` to 0.
- `mmu_enable`  out  1  level enable to `mmu`.
- `mmu_data_ready`  in  1  `mmu` completion pulse.
- `wr_valid`  out  1  `mmu` `mat_out` holds a finished tile at (tile_row, tile_col).
- `wr_ready`  in  1  writeback accepts the tile.

## Operation
- States: IDLE, LOAD, COMPUTE, WRITE, DONE. All outputs are Moore decodes of registered state and counters.
- IDLE
  - On start with all three counts nonzero: latch the counts, zero the indices, clear err, go to LOAD.
  - On start with any count zero: go directly to DONE.
- LOAD: ld_req=1. On ld_ack, go to COMPUTE. LOAD always lasts at least 1 cycle, which guarantees the `mmu` enable is low at least one cycle between operations so `data_ready` can re-pulse.
- COMPUTE: mmu_enable=1. On mmu_data_ready:
  - if tile_k==k_tiles-1, go to WRITE;
  - otherwise increment tile_k and go to LOAD. The next step reads the previous `mat_out` as its accumulate input.
- WRITE: wr_valid=1. On wr_valid & wr_ready:
  - set tile_k=0 and advance tile_col; on wrap of tile_col, advance tile_row;
  - if the last tile was written, go to DONE; otherwise go to LOAD.
- DONE: done=1 for one cycle, then return to IDLE.
- accum_clr = (LOAD or COMPUTE) & tile_k==0.
- Indices are held stable while ld_req or wr_valid is waiting. Changes to the count inputs while busy have no effect. start while busy is ignored.
- Reset (asynchronous, including mid-job): state goes to IDLE. busy, done, err, ld_req, accum_clr, mmu_enable and wr_valid go to 0. Indices and latched counts go to 0. There is no resume.

## Timing
- The `mmu` enable rises in the first COMPUTE cycle. data_ready arrives in the second cycle, so COMPUTE lasts 2 cycles. `mat_out` is registered on the edge that leaves COMPUTE, so it is valid throughout WRITE.
- With ld_ack and wr_ready tied high:
  - each K step takes 3 cycles (LOAD 1 + COMPUTE 2);
  - each tile takes 3·k_tiles + 1 cycles;
  - done is high in cycle m·n·(3k+1)+1, counting from the cycle after the start sampling edge.
- Each cycle that ld_ack or wr_ready is held low adds exactly one cycle.
- Zero-count job: done is high in the cycle after start is accepted.

## Configuration
- `MMU_CTRL_TIMEOUT_EN` defined:
  - a counter clears on COMPUTE entry and counts cycles spent in COMPUTE;
  - if it reaches TIMEOUT_CYC without mmu_data_ready, the block drops mmu_enable, sets err=1 and goes to DONE (done pulses). No wr_valid is issued for that tile.
- `MMU_CTRL_TIMEOUT_EN` undefined: no counter; err is tied to 0; COMPUTE waits indefinitely.

## Test plan
- m=n=k=1, ld_ack=wr_ready=1, behavioural `mmu` model -> one ld_req, one wr_valid at (0,0); done in cycle 5; accum_clr high in cycles 1-3.
- m=2, n=3, k=4 -> 6 writes in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); accum_clr only while tile_k==0; 24 enable pulses; done in cycle 79.
- As above with ld_ack delayed 3 cycles on the first load and wr_ready held low 5 cycles on the first write -> indices stable throughout both waits; done in cycle 87.
- k_tiles=0 with start -> done in the next cycle; ld_req, mmu_enable and wr_valid never assert.
- rst_n low during COMPUTE of tile (1,0,2) -> all outputs 0 asynchronously; a following start restarts at (0,0,0).
- `MMU_CTRL_TIMEOUT_EN` defined, TIMEOUT_CYC=8, model never pulses data_ready -> mmu_enable drops after 8 COMPUTE cycles; done pulse with err=1; err clears when the next start is accepted.
